// File: rtl/md5_pkg.sv
// Shared MD5 definitions: word width, initial chaining value, K/S step tables,
// left-rotate helper and the controller FSM state type.
package md5_pkg;

   localparam int STATE_DWIDTH = 32;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FINAL = 2'd2
   } md5_state_e;

   // K[i] = floor(abs(sin(i+1)) * 2^32)
   function automatic logic [31:0] md5_k(input logic [5:0] i);
      logic [31:0] k;
      case (i)
         6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;  6'd2:  k = 32'h242070db;  6'd3:  k = 32'hc1bdceee;
         6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;  6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;
         6'd8:  k = 32'h698098d8;  6'd9:  k = 32'h8b44f7af;  6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
         6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;  6'd14: k = 32'ha679438e;  6'd15: k = 32'h49b40821;
         6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;  6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;
         6'd20: k = 32'hd62f105d;  6'd21: k = 32'h02441453;  6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
         6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;  6'd26: k = 32'hf4d50d87;  6'd27: k = 32'h455a14ed;
         6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;  6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;
         6'd32: k = 32'hfffa3942;  6'd33: k = 32'h8771f681;  6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
         6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;  6'd38: k = 32'hf6bb4b60;  6'd39: k = 32'hbebfbc70;
         6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;  6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;
         6'd44: k = 32'hd9d4d039;  6'd45: k = 32'he6db99e5;  6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
         6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;  6'd50: k = 32'hab9423a7;  6'd51: k = 32'hfc93a039;
         6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;  6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;
         6'd56: k = 32'h6fa87e4f;  6'd57: k = 32'hfe2ce6e0;  6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
         6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;  6'd62: k = 32'h2ad7d2bb;  default: k = 32'heb86d391;
      endcase
      return k;
   endfunction

   // Shift amount depends only on the round and the step position within a group of four
   function automatic logic [4:0] md5_s(input logic [5:0] i);
      logic [4:0] s;
      case ({i[5:4], i[1:0]})
         4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
         4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
         4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
         4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] md5_rotl(input logic [31:0] x, input logic [4:0] s);
      logic [63:0] w;
      w = {x, x} << s;
      return w[63:32];
   endfunction

endpackage

// File: rtl/md5_round_func.sv
// Per-step MD5 round logic: boolean function, message word index, K constant
// and rotate amount, all derived combinationally from B, C, D and the step count.
module md5_round_func
   import md5_pkg::*;
(
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   input  logic [5:0]  step_i,
   output logic [31:0] func_o,
   output logic [3:0]  g_o,
   output logic [31:0] k_o,
   output logic [4:0]  s_o
);

   logic [3:0] i_lo;

   // The message index is taken mod 16, so only the low four step bits matter
   assign i_lo = step_i[3:0];

   always_comb begin
      func_o = '0;
      g_o    = '0;
      case (step_i[5:4])
         2'd0: begin
            func_o = (b_i & c_i) | (~b_i & d_i);
            g_o    = i_lo;
         end
         2'd1: begin
            func_o = (b_i & d_i) | (c_i & ~d_i);
            g_o    = i_lo * 4'd5 + 4'd1;
         end
         2'd2: begin
            func_o = b_i ^ c_i ^ d_i;
            g_o    = i_lo * 4'd3 + 4'd5;
         end
         default: begin
            func_o = c_i ^ (b_i | ~d_i);
            g_o    = i_lo * 4'd7;
         end
      endcase
   end

   assign k_o = md5_k(step_i);
   assign s_o = md5_s(step_i);

endmodule

// File: rtl/md5_round_ctrl.sv
// Iterative MD5 block controller: one step per clock against an external adder bank.
// Define MD5_MSG_BUF_EN to capture MsgBlock into a local register at Start.
module md5_round_ctrl #(
   parameter int STATE_DWIDTH = 32
)(
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Start,
   input  logic                    Init,
   input  logic [511:0]            MsgBlock,
   output logic                    Busy,
   output logic                    Done,
   output logic [127:0]            Digest,
   output logic [STATE_DWIDTH-1:0] Addend0A,
   output logic [STATE_DWIDTH-1:0] Addend0B,
   output logic [STATE_DWIDTH-1:0] Addend1A,
   output logic [STATE_DWIDTH-1:0] Addend1B,
   output logic [STATE_DWIDTH-1:0] Addend2A,
   output logic [STATE_DWIDTH-1:0] Addend3A,
   output logic [STATE_DWIDTH-1:0] Addend3B,
   output logic [STATE_DWIDTH-1:0] StateAReg,
   output logic [STATE_DWIDTH-1:0] StateBReg,
   output logic [STATE_DWIDTH-1:0] StateCReg,
   output logic [STATE_DWIDTH-1:0] StateDReg,
   output logic [STATE_DWIDTH-1:0] A_Reg,
   output logic [STATE_DWIDTH-1:0] B_Reg,
   output logic [STATE_DWIDTH-1:0] C_Reg,
   output logic [STATE_DWIDTH-1:0] D_Reg,
   input  logic [STATE_DWIDTH-1:0] AddResFinal1,
   input  logic [STATE_DWIDTH-1:0] AddResFinal2,
   input  logic [STATE_DWIDTH-1:0] AddResFinal3,
   input  logic [STATE_DWIDTH-1:0] ResStateAReg,
   input  logic [STATE_DWIDTH-1:0] ResStateBReg,
   input  logic [STATE_DWIDTH-1:0] ResStateCReg,
   input  logic [STATE_DWIDTH-1:0] ResStateDReg
);

   import md5_pkg::*;

   md5_state_e              state_q, state_d;
   logic [5:0]              step_q, step_d;
   logic [STATE_DWIDTH-1:0] a_q, b_q, c_q, d_q;
   logic [STATE_DWIDTH-1:0] a_d, b_d, c_d, d_d;
   logic [STATE_DWIDTH-1:0] sa_q, sb_q, sc_q, sd_q;
   logic [STATE_DWIDTH-1:0] sa_d, sb_d, sc_d, sd_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic                    start_ok;
   logic [511:0]            msg_src;
   logic [STATE_DWIDTH-1:0] msg_words [16];
   logic [STATE_DWIDTH-1:0] func;
   logic [3:0]              g_idx;
   logic [STATE_DWIDTH-1:0] k_const;
   logic [4:0]              s_amt;
   logic                    unused_sum;

`ifdef MD5_MSG_BUF_EN
   logic [511:0] msg_q, msg_d;
   assign msg_src = msg_q;
`else
   assign msg_src = MsgBlock;
`endif

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_words
         assign msg_words[gi] = msg_src[32*gi +: 32];
      end
   endgenerate

   md5_round_func u_round_func (
      .b_i    (b_q),
      .c_i    (c_q),
      .d_i    (d_q),
      .step_i (step_q),
      .func_o (func),
      .g_o    (g_idx),
      .k_o    (k_const),
      .s_o    (s_amt)
   );

   // Adder 2 is left unused by this sequencing; its sum is intentionally dropped
   assign unused_sum = ^AddResFinal2;

   assign Addend0A = a_q;
   assign Addend0B = func;
   assign Addend1A = k_const;
   assign Addend1B = msg_words[g_idx];
   assign Addend2A = '0;
   assign Addend3A = b_q;
   assign Addend3B = md5_rotl(AddResFinal1, s_amt);

   assign StateAReg = sa_q;
   assign StateBReg = sb_q;
   assign StateCReg = sc_q;
   assign StateDReg = sd_q;
   assign A_Reg     = a_q;
   assign B_Reg     = b_q;
   assign C_Reg     = c_q;
   assign D_Reg     = d_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Digest    = {sd_q, sc_q, sb_q, sa_q};

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      d_d      = d_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sc_d     = sc_q;
      sd_d     = sd_q;
      done_d   = 1'b0;
      start_ok = 1'b0;
`ifdef MD5_MSG_BUF_EN
      msg_d    = msg_q;
`endif
      case (state_q)
         ST_IDLE: begin
            start_ok = Start;
            if (Start) state_d = ST_RUN;
         end
         ST_RUN: begin
            a_d    = d_q;
            d_d    = c_q;
            c_d    = b_q;
            b_d    = AddResFinal3;
            step_d = step_q + 6'd1;
            if (step_q == 6'd63) state_d = ST_FINAL;
         end
         ST_FINAL: begin
            sa_d     = ResStateAReg;
            sb_d     = ResStateBReg;
            sc_d     = ResStateCReg;
            sd_d     = ResStateDReg;
            done_d   = 1'b1;
            // Accepting here gives back-to-back blocks a 65-cycle cadence
            start_ok = Start;
            state_d  = Start ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_ok) begin
         step_d = '0;
         if (Init) begin
            sa_d = IV_A;
            sb_d = IV_B;
            sc_d = IV_C;
            sd_d = IV_D;
         end
         a_d = sa_d;
         b_d = sb_d;
         c_d = sc_d;
         d_d = sd_d;
`ifdef MD5_MSG_BUF_EN
         msg_d = MsgBlock;
`endif
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         sa_q    <= IV_A;
         sb_q    <= IV_B;
         sc_q    <= IV_C;
         sd_q    <= IV_D;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MD5_MSG_BUF_EN
         msg_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sc_q    <= sc_d;
         sd_q    <= sd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef MD5_MSG_BUF_EN
         msg_q   <= msg_d;
`endif
      end
   end

endmodule

// File: tb/tb_md5_round_ctrl.sv
// Scoreboard bench for md5_round_ctrl: models the adder bank, predicts digests
// with a plain MD5 reference, and checks each Done against digest and cycle.
module tb_md5_round_ctrl;

   localparam logic [127:0] IV_DIGEST = 128'h10325476_98badcfe_efcdab89_67452301;

   localparam logic [31:0] KT [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };
   localparam int SH [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

   logic         Clk = 1'b0;
   logic         Reset, Start, Init;
   logic [511:0] MsgBlock;
   logic         Busy, Done;
   logic [127:0] Digest;
   logic [31:0]  Addend0A, Addend0B, Addend1A, Addend1B, Addend2A, Addend3A, Addend3B;
   logic [31:0]  StateAReg, StateBReg, StateCReg, StateDReg;
   logic [31:0]  A_Reg, B_Reg, C_Reg, D_Reg;
   logic [31:0]  AddResFinal1, AddResFinal2, AddResFinal3;
   logic [31:0]  ResStateAReg, ResStateBReg, ResStateCReg, ResStateDReg;

   always #5 Clk = ~Clk;

   md5_round_ctrl #(.STATE_DWIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Init(Init), .MsgBlock(MsgBlock),
      .Busy(Busy), .Done(Done), .Digest(Digest),
      .Addend0A(Addend0A), .Addend0B(Addend0B), .Addend1A(Addend1A), .Addend1B(Addend1B),
      .Addend2A(Addend2A), .Addend3A(Addend3A), .Addend3B(Addend3B),
      .StateAReg(StateAReg), .StateBReg(StateBReg), .StateCReg(StateCReg), .StateDReg(StateDReg),
      .A_Reg(A_Reg), .B_Reg(B_Reg), .C_Reg(C_Reg), .D_Reg(D_Reg),
      .AddResFinal1(AddResFinal1), .AddResFinal2(AddResFinal2), .AddResFinal3(AddResFinal3),
      .ResStateAReg(ResStateAReg), .ResStateBReg(ResStateBReg),
      .ResStateCReg(ResStateCReg), .ResStateDReg(ResStateDReg)
   );

   // Downstream adder bank
   assign AddResFinal1 = Addend0A + Addend0B + Addend1A + Addend1B;
   assign AddResFinal2 = Addend2A + Addend1A;
   assign AddResFinal3 = Addend3A + Addend3B;
   assign ResStateAReg = StateAReg + A_Reg;
   assign ResStateBReg = StateBReg + B_Reg;
   assign ResStateCReg = StateCReg + C_Reg;
   assign ResStateDReg = StateDReg + D_Reg;

   typedef struct {
      logic [127:0] dig;
      int unsigned  at;
   } exp_t;

   exp_t         exp_q[$];
   int unsigned  cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;
   logic [127:0] chain;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
      return (x << s) | (x >> (32 - s));
   endfunction

   function automatic logic [127:0] md5_ref(input logic [127:0] st, input logic [511:0] m);
      logic [31:0] a, b, c, d, f, t;
      int g;
      a = st[31:0]; b = st[63:32]; c = st[95:64]; d = st[127:96];
      for (int i = 0; i < 64; i++) begin
         case (i / 16)
            0:       begin f = (b & c) | (~b & d); g = i;                end
            1:       begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
            2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
         endcase
         t = rotl(a + f + KT[i] + m[32*g +: 32], SH[i/16][i%4]);
         a = d; d = c; c = b; b = b + t;
      end
      return {st[127:96] + d, st[95:64] + c, st[63:32] + b, st[31:0] + a};
   endfunction

   function automatic logic [511:0] rand_msg();
      logic [511:0] m;
      for (int j = 0; j < 16; j++) m[32*j +: 32] = $urandom;
      return m;
   endfunction

   // Monitor: every Done pops one prediction
   always @(negedge Clk) begin
      if (!Reset && Done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", {127'b0, Done}, 128'b0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("block done cyc=%0d digest=%h", cyc, Digest);
            check("digest", Digest, e.dig);
            check("done_cycle", 128'(cyc), 128'(e.at));
         end
      end
   end

   // Called at a negedge with the FSM idle; Start is sampled at the next edge
   task automatic issue(input logic init, input logic [511:0] msg);
      Start = 1'b1; Init = init; MsgBlock = msg;
      if (init) chain = IV_DIGEST;
      chain = md5_ref(chain, msg);
      exp_q.push_back('{chain, cyc + 66});
      @(negedge Clk);
      Start = 1'b0; Init = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL timeout: %0d blocks pending, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge Clk);
   endtask

   initial begin
      logic [511:0] m1, m2;
      int unsigned base;
      Reset = 1'b1; Start = 1'b0; Init = 1'b0; MsgBlock = '0;
      chain = IV_DIGEST;
      repeat (3) @(negedge Clk);
      check("rst_busy", {127'b0, Busy}, 128'b0);
      check("rst_done", {127'b0, Done}, 128'b0);
      check("rst_digest", Digest, IV_DIGEST);
      check("rst_work", {D_Reg, C_Reg, B_Reg, A_Reg}, 128'b0);
      Reset = 1'b0;
      @(negedge Clk);

      // Empty message
      m1 = '0; m1[31:0] = 32'h00000080;
      issue(1'b1, m1);
      check("busy_set", {127'b0, Busy}, 128'b1);
      wait_idle(200);
      check("empty_a", 128'(StateAReg), 128'(32'hd98c1dd4));
      check("empty_b", 128'(StateBReg), 128'(32'h04b2008f));
      check("empty_c", 128'(StateCReg), 128'(32'h980980e9));
      check("empty_d", 128'(StateDReg), 128'(32'h7e42f8ec));
      check("busy_clr", {127'b0, Busy}, 128'b0);

      // "abc"
      m1 = '0; m1[31:0] = 32'h80636261; m1[14*32 +: 32] = 32'h00000018;
      issue(1'b1, m1);
      wait_idle(200);
      check("abc_a", 128'(StateAReg), 128'(32'h98500190));
      check("abc_digest", Digest, 128'h727fe128_7d3f96d6_b04fd23c_98500190);

      // Start with Init pulsed at N+10 must be ignored
      issue(1'b0, rand_msg());
      repeat (9) @(negedge Clk);
      Start = 1'b1; Init = 1'b1;
      @(negedge Clk);
      Start = 1'b0; Init = 1'b0;
      wait_idle(200);

      // Reset at N+30 abandons the block
      issue(1'b0, rand_msg());
      repeat (29) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      exp_q.delete();
      chain = IV_DIGEST;
      check("midrst_busy", {127'b0, Busy}, 128'b0);
      check("midrst_digest", Digest, IV_DIGEST);
      check("midrst_work", {D_Reg, C_Reg, B_Reg, A_Reg}, 128'b0);
      issue(1'b0, rand_msg());
      wait_idle(200);

      // Two chained blocks with Start held high
      m1 = rand_msg(); m2 = rand_msg();
      Start = 1'b1; Init = 1'b1; MsgBlock = m1;
      base = cyc;
      chain = md5_ref(IV_DIGEST, m1);
      exp_q.push_back('{chain, base + 66});
      chain = md5_ref(chain, m2);
      exp_q.push_back('{chain, base + 131});
      @(negedge Clk);
      Init = 1'b0;
      while (cyc != base + 65) @(negedge Clk);
      MsgBlock = m2;
      @(negedge Clk);
      Start = 1'b0;
      wait_idle(300);
      check("b2b_busy_clr", {127'b0, Busy}, 128'b0);

      // Random blocks, random Init, Init toggled alone between blocks
      for (int n = 0; n < 6; n++) begin
         issue(1'($urandom_range(0, 1)), rand_msg());
         wait_idle(200);
         repeat ($urandom_range(0, 3)) begin
            Init = 1'($urandom_range(0, 1));
            @(negedge Clk);
         end
         Init = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
